// File: rtl/kernel_pr_fifo_pkg.sv
// Shared helpers for kernel_pr dataflow FIFOs: width functions and a parameter legality check.

package kernel_pr_fifo_pkg;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// Elaboration-time check; place once per module with a combined condition.
`define KPR_FIFO_PARAM_CHECK(cond) \
    if (!(cond)) begin : g_param_err \
        $error("kernel_pr_fifo: illegal parameter combination"); \
    end

// File: rtl/kernel_pr_start_bcast_fifo_shiftreg.sv
// DEPTH-entry shift register; new data enters at index 0, any entry readable by address.

module kernel_pr_start_bcast_fifo_shiftreg #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            mem[0] <= data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Addresses beyond DEPTH-1 (non-power-of-two depths) fall back to index 0.
    always_comb begin
        q = mem[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (32'(a) == i) q = mem[i];
        end
    end

endmodule

// File: rtl/kernel_pr_start_bcast_fifo.sv
// Broadcast start-token FIFO: one producer, NUM_RD consumers; an entry retires once every consumer took it.

module kernel_pr_start_bcast_fifo
    import kernel_pr_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned AF_THRESH  = 3,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned ADDR_WIDTH = clog2(DEPTH),
    localparam int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic [NUM_RD-1:0]     if_read_ce,
    input  logic [NUM_RD-1:0]     if_read,
    output logic [NUM_RD-1:0]     if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    input  logic                  err_clr,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    `KPR_FIFO_PARAM_CHECK(DATA_WIDTH >= 1 && DEPTH >= 2 && NUM_RD >= 1 &&
                          AF_THRESH >= 1 && AF_THRESH <= DEPTH && AE_THRESH <= DEPTH - 1)

    logic [NUM_RD-1:0] taken;
    logic [NUM_RD-1:0] rq;
    logic [NUM_RD-1:0] acc;
    logic              nonempty;
    logic              wr;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;

    // Status flags depend on registered state only.
    assign nonempty        = (count != '0);
    assign if_full_n       = (count != CNT_WIDTH'(DEPTH));
    assign if_empty_n      = {NUM_RD{nonempty}} & ~taken;
    assign if_almost_full  = (32'(count) >= AF_THRESH);
    assign if_almost_empty = (32'(count) <= AE_THRESH);

    always_comb begin
        wr      = if_write & if_write_ce;
        push    = wr & if_full_n;
        rq      = if_read & if_read_ce;
        acc     = rq & if_empty_n;
        pop     = nonempty & (&(taken | acc));
        ovf_set = wr & ~if_full_n;
        unf_set = |(rq & ~if_empty_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    // A consumer's taken bit holds it off the head until the last consumer retires it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken <= '0;
        end else if (pop) begin
            taken <= '0;
        end else begin
            taken <= taken | acc;
        end
    end

    // Sticky errors; a new error in the clear cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (ovf_set)      overflow_err <= 1'b1;
            else if (err_clr) overflow_err <= 1'b0;
            if (unf_set)      underflow_err <= 1'b1;
            else if (err_clr) underflow_err <= 1'b0;
        end
    end

    kernel_pr_start_bcast_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_shiftreg (
        .clk  (clk),
        .ce   (push),
        .data (if_din),
        .a    (ADDR_WIDTH'(count - CNT_WIDTH'(1))),
        .q    (if_dout)
    );

endmodule

// File: tb/tb_kernel_pr_start_bcast_fifo.sv
// Bench for kernel_pr_start_bcast_fifo: directed DEPTH=4/NUM_RD=2 and random DEPTH=3/NUM_RD=3 traffic.

module tb_kernel_pr_start_bcast_fifo;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Index 0 drives instance A (DEPTH 4, NUM_RD 2), index 1 instance B (DEPTH 3, NUM_RD 3).
    logic       wce  [2];
    logic       wrq  [2];
    logic [7:0] din  [2];
    logic [2:0] rce  [2];
    logic [2:0] rdq  [2];
    logic       eclr [2];

    logic       full_a, af_a, ae_a, ovf_a, unf_a;
    logic [1:0] en_a;
    logic [7:0] dout_a;
    logic [2:0] cnt_a;
    logic       full_b, af_b, ae_b, ovf_b, unf_b;
    logic [2:0] en_b;
    logic [7:0] dout_b;
    logic [1:0] cnt_b;

    kernel_pr_start_bcast_fifo #(
        .DATA_WIDTH(8), .DEPTH(4), .NUM_RD(2), .AF_THRESH(3), .AE_THRESH(1)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .if_write_ce(wce[0]), .if_write(wrq[0]), .if_din(din[0]),
        .if_full_n(full_a), .if_almost_full(af_a),
        .if_read_ce(rce[0][1:0]), .if_read(rdq[0][1:0]),
        .if_empty_n(en_a), .if_dout(dout_a), .if_almost_empty(ae_a),
        .count(cnt_a), .err_clr(eclr[0]),
        .overflow_err(ovf_a), .underflow_err(unf_a)
    );

    kernel_pr_start_bcast_fifo #(
        .DATA_WIDTH(8), .DEPTH(3), .NUM_RD(3), .AF_THRESH(2), .AE_THRESH(1)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .if_write_ce(wce[1]), .if_write(wrq[1]), .if_din(din[1]),
        .if_full_n(full_b), .if_almost_full(af_b),
        .if_read_ce(rce[1]), .if_read(rdq[1]),
        .if_empty_n(en_b), .if_dout(dout_b), .if_almost_empty(ae_b),
        .count(cnt_b), .err_clr(eclr[1]),
        .overflow_err(ovf_b), .underflow_err(unf_b)
    );

    logic       o_full [2], o_af [2], o_ae [2], o_ovf [2], o_unf [2];
    logic [2:0] o_en   [2];
    logic [7:0] o_dout [2];
    int         o_cnt  [2];

    always_comb begin
        o_full[0] = full_a; o_af[0] = af_a; o_ae[0] = ae_a; o_ovf[0] = ovf_a; o_unf[0] = unf_a;
        o_en[0]   = {1'b0, en_a}; o_dout[0] = dout_a; o_cnt[0] = int'(cnt_a);
        o_full[1] = full_b; o_af[1] = af_b; o_ae[1] = ae_b; o_ovf[1] = ovf_b; o_unf[1] = unf_b;
        o_en[1]   = en_b; o_dout[1] = dout_b; o_cnt[1] = int'(cnt_b);
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    // Scoreboard: accepted tokens pushed once, each consumer pops with its own read index.
    logic [7:0] tok    [2][64];
    int         wr_idx [2];
    int         rd_idx [2][3];
    bit         m_ovf  [2];
    bit         m_unf  [2];

    task automatic model_step(input int i, input int nrd, input int depth, input int af, input int ae);
        int mn;
        int occ;
        bit exp_en [3];
        bit set_o;
        bit set_u;
        if (reset) begin
            check("rst_count", i, o_cnt[i], 0);
            check("rst_full_n", i, int'(o_full[i]), 1);
            check("rst_empty_n", i, int'(o_en[i]), 0);
            check("rst_almost_full", i, int'(o_af[i]), 0);
            check("rst_almost_empty", i, int'(o_ae[i]), 1);
            check("rst_overflow", i, int'(o_ovf[i]), 0);
            check("rst_underflow", i, int'(o_unf[i]), 0);
            for (int k = 0; k < 3; k++) rd_idx[i][k] = wr_idx[i];
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            return;
        end
        mn = rd_idx[i][0];
        for (int k = 1; k < nrd; k++) if (rd_idx[i][k] < mn) mn = rd_idx[i][k];
        occ = wr_idx[i] - mn;
        check("count", i, o_cnt[i], occ);
        check("full_n", i, int'(o_full[i]), int'(occ != depth));
        check("almost_full", i, int'(o_af[i]), int'(occ >= af));
        check("almost_empty", i, int'(o_ae[i]), int'(occ <= ae));
        check("overflow_err", i, int'(o_ovf[i]), int'(m_ovf[i]));
        check("underflow_err", i, int'(o_unf[i]), int'(m_unf[i]));
        for (int k = 0; k < nrd; k++) begin
            exp_en[k] = (occ > 0) && (wr_idx[i] - rd_idx[i][k] == occ);
            check("empty_n", i, int'(o_en[i][k]), int'(exp_en[k]));
        end
        set_o = 1'b0;
        set_u = 1'b0;
        for (int k = 0; k < nrd; k++) begin
            if (rdq[i][k] && rce[i][k]) begin
                if (exp_en[k]) begin
                    check("dout", i, int'(o_dout[i]), int'(tok[i][rd_idx[i][k] % 64]));
                    rd_idx[i][k]++;
                end else begin
                    set_u = 1'b1;
                end
            end
        end
        if (wrq[i] && wce[i]) begin
            if (occ == depth) begin
                set_o = 1'b1;
            end else begin
                tok[i][wr_idx[i] % 64] = din[i];
                wr_idx[i]++;
            end
        end
        if (set_o)        m_ovf[i] = 1'b1;
        else if (eclr[i]) m_ovf[i] = 1'b0;
        if (set_u)        m_unf[i] = 1'b1;
        else if (eclr[i]) m_unf[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        model_step(0, 2, 4, 3, 1);
        model_step(1, 3, 3, 2, 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            wce[i] = 1'b0; wrq[i] = 1'b0; din[i] = 8'h00;
            rce[i] = 3'b000; rdq[i] = 3'b000; eclr[i] = 1'b0;
            wr_idx[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
            for (int k = 0; k < 3; k++) rd_idx[i][k] = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fill to full, then one dropped write.
        wce[0] = 1'b1; wrq[0] = 1'b1; rce[0] = 3'b011;
        din[0] = 8'h0A; step(); check("t1_cnt1", 0, o_cnt[0], 1);
        din[0] = 8'h0B; step(); check("t1_cnt2", 0, o_cnt[0], 2);
        check("t1_ae_at2", 0, int'(o_ae[0]), 0);
        din[0] = 8'h0C; step(); check("t1_cnt3", 0, o_cnt[0], 3);
        check("t1_af_at3", 0, int'(o_af[0]), 1);
        check("t1_full_n_at3", 0, int'(o_full[0]), 1);
        din[0] = 8'h0D; step(); check("t1_cnt4", 0, o_cnt[0], 4);
        check("t1_full_n_at4", 0, int'(o_full[0]), 0);
        din[0] = 8'h0E; step(); check("t1_cnt_drop", 0, o_cnt[0], 4);
        check("t1_overflow", 0, int'(o_ovf[0]), 1);
        wrq[0] = 1'b0;
        eclr[0] = 1'b1; step(); eclr[0] = 1'b0;
        check("t1_ovf_clr", 0, int'(o_ovf[0]), 0);
        check("t1_head", 0, int'(o_dout[0]), 8'h0A);

        // Staggered consumers on one entry.
        rdq[0] = 3'b001; step(); rdq[0] = 3'b000;
        check("t2_en_t1", 0, int'(o_en[0]), 2);
        step();
        check("t2_en_t2", 0, int'(o_en[0]), 2);
        check("t2_cnt_t2", 0, o_cnt[0], 4);
        rdq[0] = 3'b010; step(); rdq[0] = 3'b000;
        check("t2_cnt_pop", 0, o_cnt[0], 3);
        check("t2_dout", 0, int'(o_dout[0]), 8'h0B);
        check("t2_en_both", 0, int'(o_en[0]), 3);
        check("t2_full_n", 0, int'(o_full[0]), 1);
        rdq[0] = 3'b011; step(); check("t2_dout_c", 0, int'(o_dout[0]), 8'h0C);
        step(); rdq[0] = 3'b000;
        check("t2_cnt1", 0, o_cnt[0], 1);
        check("t2_dout_d", 0, int'(o_dout[0]), 8'h0D);

        // Pop and push together at count 1.
        rdq[0] = 3'b011; wrq[0] = 1'b1; din[0] = 8'h55; step();
        rdq[0] = 3'b000; wrq[0] = 1'b0;
        check("t3_cnt", 0, o_cnt[0], 1);
        check("t3_dout", 0, int'(o_dout[0]), 8'h55);
        check("t3_en", 0, int'(o_en[0]), 3);

        // Re-read after taken, error clear, clear colliding with a new error.
        rdq[0] = 3'b001; step();
        check("t5_taken", 0, int'(o_en[0]), 2);
        step(); rdq[0] = 3'b000;
        check("t5_unf", 0, int'(o_unf[0]), 1);
        check("t5_cnt", 0, o_cnt[0], 1);
        check("t5_en_kept", 0, int'(o_en[0]), 2);
        eclr[0] = 1'b1; step(); eclr[0] = 1'b0;
        check("t5_unf_clr", 0, int'(o_unf[0]), 0);
        rdq[0] = 3'b010; step();
        check("t5_cnt0", 0, o_cnt[0], 0);
        check("t5_en0", 0, int'(o_en[0]), 0);
        eclr[0] = 1'b1; step(); eclr[0] = 1'b0; rdq[0] = 3'b000;
        check("t5_set_wins", 0, int'(o_unf[0]), 1);
        eclr[0] = 1'b1; step(); eclr[0] = 1'b0;

        // Full, pop plus write in same cycle: write dropped.
        wrq[0] = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            din[0] = 8'(d); step();
        end
        check("t4_cnt4", 0, o_cnt[0], 4);
        rdq[0] = 3'b011; din[0] = 8'h09; step(); rdq[0] = 3'b000;
        check("t4_ovf", 0, int'(o_ovf[0]), 1);
        check("t4_cnt3", 0, o_cnt[0], 3);
        check("t4_dout", 0, int'(o_dout[0]), 2);
        step(); wrq[0] = 1'b0;
        check("t4_cnt_refill", 0, o_cnt[0], 4);
        rdq[0] = 3'b011; repeat (4) step(); rdq[0] = 3'b000;
        check("t4_drained", 0, o_cnt[0], 0);
        eclr[0] = 1'b1; step(); eclr[0] = 1'b0;
        wce[0] = 1'b0; rce[0] = 3'b000;

        // Random traffic on the three-consumer instance with a mid-burst reset.
        for (int c = 0; c < 10000; c++) begin
            wce[1]  = 1'($urandom_range(0, 3) != 0);
            wrq[1]  = 1'($urandom_range(0, 1));
            din[1]  = 8'($urandom);
            rce[1]  = 3'($urandom);
            rdq[1]  = 3'($urandom) | 3'($urandom);
            eclr[1] = 1'($urandom_range(0, 31) == 0);
            if (c == 5000) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1 check("mid_rst_cnt", 1, o_cnt[1], 0);
                check("mid_rst_en", 1, int'(o_en[1]), 0);
                check("mid_rst_full_n", 1, int'(o_full[1]), 1);
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
            end else begin
                step();
            end
        end
        wce[1] = 1'b0; wrq[1] = 1'b0; rdq[1] = 3'b000; eclr[1] = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
